// File: rtl/clkscale_arbiter.sv
// -----------------------------------------------------------------------------
// clkscale_arbiter
//   Shares one CCLK-domain clock divider between NREQ requesters. Each
//   requester asks for its own divider scale. The arbiter grants one owner at
//   a time and drives that owner's scale onto clkscale. The switch happens
//   only on an observed divider toggle (or after TIMEOUT cycles without one),
//   so divider periods stay clean. A grant lasts HOLD full divider periods, or
//   ends early when the owner drops req.
//
//   Build option: define CLKSCALE_ARB_PRIO_EN for fixed priority (lowest
//   index wins, no preemption). Left undefined, arbitration is round-robin,
//   and the requester just served has the lowest priority.
//
// Ports
//   CCLK      in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]   level request per requester
//   scale_in  in   [NREQ*W] requested scale, requester i at [i*W +: W]
//   div_clk   in   divider output (CCLK-synchronous)
//   clkscale  out  [W]      registered scale driven to the divider
//   grant     out  [NREQ]   registered one-hot owner, 0 when idle
//   busy      out  high while pending or running a grant
//   done      out  [NREQ]   one-cycle pulse on the owner's bit at release
// -----------------------------------------------------------------------------
module clkscale_arbiter #(
  parameter int           NREQ      = 4,
  parameter int           W         = 32,
  parameter int           HOLD      = 16,
  parameter logic [W-1:0] DEF_SCALE = W'(24_999_999),
  parameter int           TIMEOUT   = 65535
) (
  input  logic              CCLK,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] scale_in,
  input  logic              div_clk,
  output logic [W-1:0]      clkscale,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [NREQ-1:0]   done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (2*HOLD > 1) ? $clog2(2*HOLD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, PEND, RUN} state_t;

  state_t        state_q, state_d;
  logic          div_clk_q;
  logic [W-1:0]  scale_lat_q, scale_lat_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  clkscale_q, clkscale_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic          tog;
  logic [IW-1:0] win;

  // Divider output is already CCLK-synchronous; an edge is any change since
  // the previous cycle.
  assign tog = div_clk ^ div_clk_q;

`ifdef CLKSCALE_ARB_PRIO_EN
  // Fixed priority: scan high to low so the lowest set index is kept last.
  always_comb begin
    win = '0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin: candidates rr_ptr+1 .. rr_ptr+NREQ (mod NREQ). Scanning the
  // offsets downwards leaves the nearest set request as the winner, which puts
  // the last owner (offset NREQ) at the bottom.
  always_comb begin
    win = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(rr_ptr_q) + k) % NREQ]) win = IW'((int'(rr_ptr_q) + k) % NREQ);
  end
`endif

  always_comb begin
    state_d     = state_q;
    scale_lat_d = scale_lat_q;
    owner_d     = owner_q;
    tcnt_d      = tcnt_q;
    cnt_d       = cnt_q;
    clkscale_d  = clkscale_q;
    grant_d     = grant_q;
    done_d      = '0;
`ifdef CLKSCALE_ARB_PRIO_EN
`else
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          scale_lat_d = scale_in[win*W +: W];
          owner_d     = win;
          tcnt_d      = '0;
          state_d     = PEND;
        end
      end
      PEND: begin
        // A withdrawn request abandons the switch silently.
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (tog || tcnt_q == TW'(TIMEOUT-1)) begin
          clkscale_d       = scale_lat_q;
          grant_d          = '0;
          grant_d[owner_q] = 1'b1;
          cnt_d            = '0;
          state_d          = RUN;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RUN: begin
        // Final toggle and a req drop in the same cycle share this branch,
        // so only one done pulse is produced.
        if ((tog && cnt_q == CW'(2*HOLD-1)) || !req[owner_q]) begin
          grant_d         = '0;
          done_d[owner_q] = 1'b1;
`ifdef CLKSCALE_ARB_PRIO_EN
`else
          rr_ptr_d        = owner_q;
`endif
          state_d         = IDLE;
        end else if (tog) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_clk_q   <= 1'b0;
      scale_lat_q <= '0;
      owner_q     <= '0;
      tcnt_q      <= '0;
      cnt_q       <= '0;
      clkscale_q  <= DEF_SCALE;
      grant_q     <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_clk_q   <= div_clk;
      scale_lat_q <= scale_lat_d;
      owner_q     <= owner_d;
      tcnt_q      <= tcnt_d;
      cnt_q       <= cnt_d;
      clkscale_q  <= clkscale_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
    end
  end

`ifdef CLKSCALE_ARB_PRIO_EN
`else
  always_ff @(posedge CCLK or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= IW'(NREQ-1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign clkscale = clkscale_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_clkscale_arbiter.sv
`timescale 1ns/1ps
module tb_clkscale_arbiter;
  localparam int NREQ = 4, W = 32, HOLD = 2, TIMEOUT = 20;
  localparam logic [W-1:0] DEF = 32'd3;

  logic CCLK = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] scale_in = '0;
  logic div_clk = 1'b0, div_chg = 1'b0, div_en = 1'b1;
  int dcnt = 0;
  logic [W-1:0] clkscale;
  logic [NREQ-1:0] grant, done;
  logic busy;
  int n_chk = 0, n_pass = 0;

  clkscale_arbiter #(.NREQ(NREQ), .W(W), .HOLD(HOLD), .DEF_SCALE(DEF), .TIMEOUT(TIMEOUT)) dut (
    .CCLK(CCLK), .rst_n(rst_n), .req(req), .scale_in(scale_in), .div_clk(div_clk),
    .clkscale(clkscale), .grant(grant), .busy(busy), .done(done));

  always #5 CCLK = ~CCLK;

  // Divider model: half period of clkscale+1 CCLK cycles. div_chg flags that
  // div_clk changed at the most recent posedge.
  always @(posedge CCLK) begin
    if (div_en && dcnt >= int'(clkscale)) begin
      div_clk <= ~div_clk; dcnt <= 0; div_chg <= 1'b1;
    end else begin
      if (div_en) dcnt <= dcnt + 1;
      div_chg <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference arbitration rule.
  function automatic int pick(input logic [NREQ-1:0] m, input int last);
    int w; w = -1;
`ifdef CLKSCALE_ARB_PRIO_EN
    for (int i = NREQ-1; i >= 0; i--) if (m[i]) w = i;
`else
    for (int k = NREQ; k >= 1; k--) if (m[(last + k) % NREQ]) w = (last + k) % NREQ;
`endif
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge CCLK);
    rst_n = 1'b1;
    @(negedge CCLK);
  endtask

  // Called at the negedge where requests were settled. Returns the first
  // grant seen and whether it came exactly one cycle after the first divider
  // change following the anchor.
  task automatic wait_grant(output logic [NREQ-1:0] g, output logic [W-1:0] sc,
                            output bit tim_ok, output bit to);
    int first; first = -1; g = '0; sc = '0; tim_ok = 0; to = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CCLK);
      if (grant != '0) begin g = grant; sc = clkscale; tim_ok = (first == k-1); to = 0; break; end
      if (div_chg && first < 0) first = k;
    end
  endtask

  // Called at the negedge where the grant first appears. Counts divider
  // changes that the owner's hold window sees, until done shows up.
  task automatic wait_done(input logic [NREQ-1:0] gexp, output logic [NREQ-1:0] dn,
                           output int togs, output bit last_tog, output bit steady, output bit to);
    togs = div_chg ? 1 : 0; last_tog = div_chg; steady = 1; to = 1; dn = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CCLK);
      if (done != '0) begin dn = done; to = 0; break; end
      if (grant !== gexp || busy !== 1'b1) steady = 0;
      if (div_chg) togs++;
      last_tog = div_chg;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; div_en = 1'b1;
    repeat (3) @(negedge CCLK);
    n_chk++; if ({clkscale, grant, busy, done} !== {DEF, 4'b0, 1'b0, 4'b0})
      $display("FAIL reset_hold: got cs=%0d g=%b b=%b d=%b exp cs=3 g=0 b=0 d=0", clkscale, grant, busy, done); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge CCLK);
    n_chk++; if ({clkscale, grant, busy, done} !== {DEF, 4'b0, 1'b0, 4'b0})
      $display("FAIL reset_release: got cs=%0d g=%b b=%b d=%b exp cs=3 g=0 b=0 d=0", clkscale, grant, busy, done); else n_pass++;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g, dn; logic [W-1:0] sc; bit tim, to, lt, st; int tg;
    do_reset();
    scale_in[1*W +: W] = 32'd5; req = 4'b0010;
    wait_grant(g, sc, tim, to);
    n_chk++; if (to || g !== 4'b0010 || sc !== 32'd5 || !tim)
      $display("FAIL single_grant: got g=%b cs=%0d tim=%0d to=%0d exp g=0010 cs=5 tim=1", g, sc, tim, to); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b exp 1", busy); else n_pass++;
    wait_done(g, dn, tg, lt, st, to);
    n_chk++; if (to || dn !== 4'b0010 || tg != 2*HOLD || !lt || !st)
      $display("FAIL single_done: got d=%b togs=%0d last=%0d steady=%0d exp d=0010 togs=4 last=1 steady=1", dn, tg, lt, st); else n_pass++;
    n_chk++; if (grant !== 4'b0 || clkscale !== 32'd5)
      $display("FAIL single_release: got g=%b cs=%0d exp g=0 cs=5", grant, clkscale); else n_pass++;
    req = '0;
    @(negedge CCLK);
    n_chk++; if (done !== 4'b0 || busy !== 1'b0 || clkscale !== 32'd5)
      $display("FAIL single_pulse: got d=%b b=%b cs=%0d exp d=0 b=0 cs=5", done, busy, clkscale); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g, dn, exp_g [4]; logic [W-1:0] sc; bit tim, to, lt, st; int tg;
`ifdef CLKSCALE_ARB_PRIO_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
`endif
    do_reset();
    for (int i = 0; i < NREQ; i++) scale_in[i*W +: W] = W'(i + 1);
    req = 4'b1011;
    for (int r = 0; r < 4; r++) begin
      wait_grant(g, sc, tim, to);
      n_chk++; if (to || g !== exp_g[r] || !tim)
        $display("FAIL rr_grant%0d: got g=%b tim=%0d to=%0d exp g=%b tim=1", r, g, tim, to, exp_g[r]); else n_pass++;
      wait_done(g, dn, tg, lt, st, to);
      n_chk++; if (to || dn !== exp_g[r] || tg != 2*HOLD)
        $display("FAIL rr_done%0d: got d=%b togs=%0d exp d=%b togs=4", r, dn, tg, exp_g[r]); else n_pass++;
    end
    req = '0;
    @(negedge CCLK);
  endtask

  task automatic test_early_drop();
    logic [NREQ-1:0] g; logic [W-1:0] sc; bit tim, to;
    do_reset();
    scale_in[2*W +: W] = 32'd2; scale_in[3*W +: W] = 32'd4;
    req = 4'b1100;
    wait_grant(g, sc, tim, to);
    n_chk++; if (to || g !== 4'b0100 || sc !== 32'd2)
      $display("FAIL drop_grant2: got g=%b cs=%0d exp g=0100 cs=2", g, sc); else n_pass++;
    for (int k = 0; k < 20 && !div_chg; k++) @(negedge CCLK);
    req = 4'b1000;
    @(negedge CCLK);
    n_chk++; if (done !== 4'b0100 || grant !== 4'b0)
      $display("FAIL drop_done2: got d=%b g=%b exp d=0100 g=0", done, grant); else n_pass++;
    wait_grant(g, sc, tim, to);
    n_chk++; if (to || g !== 4'b1000 || sc !== 32'd4 || !tim)
      $display("FAIL drop_grant3: got g=%b cs=%0d tim=%0d exp g=1000 cs=4 tim=1", g, sc, tim); else n_pass++;
    req = '0;
    @(negedge CCLK);
    n_chk++; if (done !== 4'b1000 || grant !== 4'b0)
      $display("FAIL drop_done3: got d=%b g=%b exp d=1000 g=0", done, grant); else n_pass++;
  endtask

  task automatic test_timeout();
    bit early, seen_done;
    do_reset();
    div_en = 1'b0;
    @(negedge CCLK);
    // Withdrawn while pending: no grant, no done, scale untouched.
    scale_in[1*W +: W] = 32'd9; req = 4'b0010;
    repeat (5) @(negedge CCLK);
    req = '0; seen_done = 0;
    repeat (3) begin @(negedge CCLK); if (done != '0) seen_done = 1; end
    n_chk++; if (seen_done || grant !== 4'b0 || busy !== 1'b0 || clkscale !== DEF)
      $display("FAIL pend_drop: got done=%0d g=%b b=%b cs=%0d exp done=0 g=0 b=0 cs=3", seen_done, grant, busy, clkscale); else n_pass++;
    scale_in[0 +: W] = 32'd7; req = 4'b0001; early = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CCLK);
      if (grant != '0) early = 1;
    end
    n_chk++; if (early || busy !== 1'b1)
      $display("FAIL timeout_early: got early=%0d b=%b exp early=0 b=1", early, busy); else n_pass++;
    @(negedge CCLK);
    n_chk++; if (grant !== 4'b0001 || clkscale !== 32'd7)
      $display("FAIL timeout_grant: got g=%b cs=%0d exp g=0001 cs=7", grant, clkscale); else n_pass++;
    req = '0;
    @(negedge CCLK);
    n_chk++; if (done !== 4'b0001 || grant !== 4'b0)
      $display("FAIL timeout_done: got d=%b g=%b exp d=0001 g=0", done, grant); else n_pass++;
    div_en = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    logic [NREQ-1:0] g; logic [W-1:0] sc; bit tim, to, seen_done;
    do_reset();
    scale_in[1*W +: W] = 32'd4; req = 4'b0010;
    wait_grant(g, sc, tim, to);
    n_chk++; if (to || g !== 4'b0010)
      $display("FAIL rstrun_grant: got g=%b exp g=0010", g); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0 || clkscale !== DEF || done !== 4'b0 || busy !== 1'b0)
      $display("FAIL rstrun_async: got g=%b cs=%0d d=%b b=%b exp g=0 cs=3 d=0 b=0", grant, clkscale, done, busy); else n_pass++;
    seen_done = 0;
    repeat (3) begin @(negedge CCLK); if (done != '0) seen_done = 1; end
    n_chk++; if (seen_done) $display("FAIL rstrun_nodone: got done pulse exp none"); else n_pass++;
    req = '0; rst_n = 1'b1;
    @(negedge CCLK);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] m, g, dn, gexp; logic [W-1:0] sc, scl [NREQ]; bit tim, to, lt, st;
    int tg, last, w, bad;
    do_reset();
    last = NREQ - 1; bad = 0;
    m = 4'($urandom_range(1, 15));
    for (int i = 0; i < NREQ; i++) begin
      scl[i] = W'($urandom_range(0, 6)); scale_in[i*W +: W] = scl[i];
    end
    req = m;
    for (int r = 0; r < 12; r++) begin
      w = pick(m, last);
      gexp = '0; gexp[w] = 1'b1;
      wait_grant(g, sc, tim, to);
      n_chk++; if (to || g !== gexp || sc !== scl[w] || !tim)
        $display("FAIL rand_grant%0d: got g=%b cs=%0d tim=%0d exp g=%b cs=%0d tim=1", r, g, sc, tim, gexp, scl[w]); else n_pass++;
      // Owner changes its request scale while running; output must not move.
      scl[w] = W'($urandom_range(0, 6)); scale_in[w*W +: W] = scl[w];
      wait_done(gexp, dn, tg, lt, st, to);
      n_chk++; if (to || dn !== gexp || tg != 2*HOLD || !lt || !st || grant !== 4'b0 || clkscale !== sc)
        $display("FAIL rand_done%0d: got d=%b togs=%0d last=%0d steady=%0d g=%b cs=%0d exp d=%b togs=4 cs=%0d",
                 r, dn, tg, lt, st, grant, clkscale, gexp, sc); else n_pass++;
      last = w;
      if ($urandom_range(0, 1) == 0) m[w] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (i != w && !m[i] && $urandom_range(0, 9) < 3) begin
          m[i] = 1'b1; scl[i] = W'($urandom_range(0, 6)); scale_in[i*W +: W] = scl[i];
        end
      if (m == '0) m[$urandom_range(0, NREQ-1)] = 1'b1;
      req = m;
    end
    req = '0;
    repeat (2) @(negedge CCLK);
    if (done != '0) bad = 1;
    n_chk++; if (bad || busy !== 1'b0)
      $display("FAIL rand_idle: got d=%b b=%b exp d=0 b=0", done, busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
